// File: rtl/draw_scheduler.sv
// Per-frame draw sequencer: background clear, then one round-robin plot slot per requesting controller.
// Latency: tick->CLEAR 1 cycle, CLEAR plot_done->first grant 2 cycles, one idle ARB cycle between slots.
// Backpressure: slots advance only on plot_done; ticks while busy are dropped (frame_overrun). Option: DRAW_SCHED_COLLISION_EN.
module draw_scheduler #(
    parameter int          NUM_CH    = 4,
    parameter int          SW        = 4,
    parameter logic [SW-1:0] IDLE_CODE = 4'b1011,
    parameter logic [SW-1:0] BG_CODE   = 4'b0000,
    parameter logic [SW-1:0] OVER_CODE = 4'b1111
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      frame_tick,
    input  logic [NUM_CH-1:0]         req,
    input  logic [NUM_CH*SW-1:0]      ch_state,
    input  logic                      plot_done,
    input  logic                      collision,
    output logic [NUM_CH-1:0]         grant,
    output logic [$clog2(NUM_CH)-1:0] cur_ch,
    output logic [SW-1:0]             cur_state,
    output logic                      bg_active,
    output logic                      frame_busy,
    output logic                      frame_overrun,
    output logic                      game_over
);
    localparam int CW = $clog2(NUM_CH);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_ARB, S_DRAW} state_t;

    state_t            state, state_nxt;
    logic [NUM_CH-1:0] pending, pending_nxt;
    logic [CW-1:0]     rr_ptr, rr_nxt;
    logic [NUM_CH-1:0] grant_nxt;
    logic [CW-1:0]     cur_ch_nxt;
    logic [SW-1:0]     cur_state_nxt;
    logic              overrun_nxt;
    logic              go_nxt;
    logic              pick_vld;
    logic [CW-1:0]     pick;
    logic [CW:0]       scan_idx;

`ifdef DRAW_SCHED_COLLISION_EN
    assign go_nxt = game_over | (frame_busy & collision);
`else
    logic unused_collision;
    assign unused_collision = collision;
    assign go_nxt           = 1'b0;
`endif

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        scan_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            scan_idx = {1'b0, rr_ptr} + (CW+1)'(i);
            if (scan_idx >= (CW+1)'(NUM_CH))
                scan_idx = scan_idx - (CW+1)'(NUM_CH);
            if (pending[scan_idx[CW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = scan_idx[CW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        pending_nxt   = pending;
        rr_nxt        = rr_ptr;
        grant_nxt     = grant;
        cur_ch_nxt    = cur_ch;
        cur_state_nxt = cur_state;
        overrun_nxt   = frame_tick & frame_busy & ~game_over;
        case (state)
            S_IDLE: begin
                if (frame_tick && !game_over)
                    state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                if (plot_done) begin
                    pending_nxt = req;
                    state_nxt   = S_ARB;
                end
            end
            S_ARB: begin
                if (pick_vld) begin
                    grant_nxt       = '0;
                    grant_nxt[pick] = 1'b1;
                    cur_ch_nxt      = pick;
                    cur_state_nxt   = ch_state[int'(pick)*SW +: SW];
                    state_nxt       = S_DRAW;
                end else begin
                    rr_nxt    = (rr_ptr == CW'(NUM_CH - 1)) ? '0 : rr_ptr + 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_DRAW: begin
                if (plot_done) begin
                    pending_nxt[cur_ch] = 1'b0;
                    grant_nxt           = '0;
                    cur_ch_nxt          = '0;
                    state_nxt           = S_ARB;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // The datapath code follows the state being entered; DRAW keeps its latched slot code.
        if (state_nxt == S_IDLE || state_nxt == S_ARB)
            cur_state_nxt = go_nxt ? OVER_CODE : IDLE_CODE;
        else if (state_nxt == S_CLEAR)
            cur_state_nxt = BG_CODE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            pending       <= '0;
            rr_ptr        <= '0;
            grant         <= '0;
            cur_ch        <= '0;
            cur_state     <= IDLE_CODE;
            bg_active     <= 1'b0;
            frame_busy    <= 1'b0;
            frame_overrun <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            state         <= state_nxt;
            pending       <= pending_nxt;
            rr_ptr        <= rr_nxt;
            grant         <= grant_nxt;
            cur_ch        <= cur_ch_nxt;
            cur_state     <= cur_state_nxt;
            bg_active     <= (state_nxt == S_CLEAR);
            frame_busy    <= (state_nxt != S_IDLE);
            frame_overrun <= overrun_nxt;
            game_over     <= go_nxt;
        end
    end
endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler (NUM_CH=4, SW=4); honours DRAW_SCHED_COLLISION_EN if defined.
module tb_draw_scheduler;
    logic        clk = 1'b0;
    logic        resetn;
    logic        frame_tick;
    logic [3:0]  req;
    logic [15:0] ch_state;
    logic        plot_done;
    logic        collision;
    logic [3:0]  grant;
    logic [1:0]  cur_ch;
    logic [3:0]  cur_state;
    logic        bg_active;
    logic        frame_busy;
    logic        frame_overrun;
    logic        game_over;

    int checks = 0;
    int errors = 0;

`ifdef DRAW_SCHED_COLLISION_EN
    localparam logic GO_EXP = 1'b1;
`else
    localparam logic GO_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    draw_scheduler #(.NUM_CH(4), .SW(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .frame_tick   (frame_tick),
        .req          (req),
        .ch_state     (ch_state),
        .plot_done    (plot_done),
        .collision    (collision),
        .grant        (grant),
        .cur_ch       (cur_ch),
        .cur_state    (cur_state),
        .bg_active    (bg_active),
        .frame_busy   (frame_busy),
        .frame_overrun(frame_overrun),
        .game_over    (game_over)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Tick into CLEAR, then finish the clear; leaves the DUT in its ARB cycle.
    task automatic start_frame(input logic [3:0] r, input string tag);
        req        = r;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk({tag, ".clr_bg"},    bg_active, 1);
        chk({tag, ".clr_busy"},  frame_busy, 1);
        chk({tag, ".clr_state"}, cur_state, 4'h0);
        chk({tag, ".clr_grant"}, grant, 0);
        plot_done = 1'b1;
        cyc();
        plot_done = 1'b0;
        chk({tag, ".arb_bg"},    bg_active, 0);
        chk({tag, ".arb_grant"}, grant, 0);
        chk({tag, ".arb_busy"},  frame_busy, 1);
    endtask

    // From ARB: enter DRAW, hold one extra cycle, finish with plot_done back into ARB.
    task automatic serve_slot(input logic [3:0] g, input logic [1:0] ch, input logic [3:0] st,
                              input string tag);
        cyc();
        chk({tag, ".grant"},      grant, g);
        chk({tag, ".cur_ch"},     cur_ch, ch);
        chk({tag, ".state"},      cur_state, st);
        cyc();
        chk({tag, ".grant_hold"}, grant, g);
        chk({tag, ".state_hold"}, cur_state, st);
        plot_done = 1'b1;
        cyc();
        plot_done = 1'b0;
        chk({tag, ".gap_grant"},  grant, 0);
        chk({tag, ".gap_ch"},     cur_ch, 0);
    endtask

    task automatic end_frame(input string tag);
        cyc();
        chk({tag, ".idle_busy"},  frame_busy, 0);
        chk({tag, ".idle_grant"}, grant, 0);
        chk({tag, ".idle_state"}, cur_state, 4'hB);
    endtask

    initial begin
        resetn     = 1'b0;
        frame_tick = 1'b0;
        req        = 4'b0;
        ch_state   = {4'h4, 4'h3, 4'h2, 4'h1};
        plot_done  = 1'b0;
        collision  = 1'b0;
        cyc();
        cyc();
        chk("rst.grant",   grant, 0);
        chk("rst.cur_ch",  cur_ch, 0);
        chk("rst.state",   cur_state, 4'hB);
        chk("rst.bg",      bg_active, 0);
        chk("rst.busy",    frame_busy, 0);
        chk("rst.overrun", frame_overrun, 0);
        chk("rst.go",      game_over, 0);
        resetn = 1'b1;
        cyc();

        // 1: reset while ch1 owns the plotter
        start_frame(4'b0010, "t1");
        cyc();
        chk("t1.draw_grant", grant, 4'b0010);
        resetn = 1'b0;
        #1;
        chk("t1.rst_grant", grant, 0);
        chk("t1.rst_state", cur_state, 4'hB);
        chk("t1.rst_busy",  frame_busy, 0);
        chk("t1.rst_go",    game_over, 0);
        cyc();
        resetn = 1'b1;
        cyc();
        chk("t1.after_busy", frame_busy, 0);
        chk("t1.after_bg",   bg_active, 0);

        // 2: rr_ptr=0 -> ch0, ch1, ch3
        start_frame(4'b1011, "t2");
        serve_slot(4'b0001, 2'd0, 4'h1, "t2.s0");
        serve_slot(4'b0010, 2'd1, 4'h2, "t2.s1");
        serve_slot(4'b1000, 2'd3, 4'h4, "t2.s2");
        end_frame("t2");

        // 3: rotation -> ch1, ch3, ch0 then ch3, ch0, ch1
        start_frame(4'b1011, "t3a");
        serve_slot(4'b0010, 2'd1, 4'h2, "t3a.s0");
        serve_slot(4'b1000, 2'd3, 4'h4, "t3a.s1");
        serve_slot(4'b0001, 2'd0, 4'h1, "t3a.s2");
        end_frame("t3a");
        start_frame(4'b1011, "t3b");
        serve_slot(4'b1000, 2'd3, 4'h4, "t3b.s0");
        serve_slot(4'b0001, 2'd0, 4'h1, "t3b.s1");
        serve_slot(4'b0010, 2'd1, 4'h2, "t3b.s2");
        end_frame("t3b");

        // 4: empty frame -> CLEAR, ARB, IDLE (rr_ptr wraps 3 -> 0)
        start_frame(4'b0000, "t4");
        end_frame("t4");

        // 5: overrun during DRAW, req toggled mid-frame, overrun on ARB->IDLE edge
        start_frame(4'b1011, "t5");
        req = 4'b0100;
        cyc();
        chk("t5.s0_grant", grant, 4'b0001);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("t5.ovr_pulse", frame_overrun, 1);
        chk("t5.ovr_grant", grant, 4'b0001);
        cyc();
        chk("t5.ovr_clear", frame_overrun, 0);
        plot_done = 1'b1;
        cyc();
        plot_done = 1'b0;
        chk("t5.s0_gap", grant, 0);
        serve_slot(4'b0010, 2'd1, 4'h2, "t5.s1");
        serve_slot(4'b1000, 2'd3, 4'h4, "t5.s2");
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("t5.end_ovr",  frame_overrun, 1);
        chk("t5.end_busy", frame_busy, 0);
        chk("t5.end_bg",   bg_active, 0);
        cyc();
        chk("t5.end_ovr_clr", frame_overrun, 0);
        chk("t5.no_clear",    bg_active, 0);
        plot_done = 1'b1;
        cyc();
        plot_done = 1'b0;
        chk("t5.pd_idle_bg",   bg_active, 0);
        chk("t5.pd_idle_busy", frame_busy, 0);

        // 6: collision while ch0 draws (rr_ptr moved to 2 by an empty frame)
        start_frame(4'b0000, "t6e");
        end_frame("t6e");
        start_frame(4'b1011, "t6");
        serve_slot(4'b1000, 2'd3, 4'h4, "t6.s0");
        cyc();
        chk("t6.ch0_grant", grant, 4'b0001);
        collision = 1'b1;
        cyc();
        collision = 1'b0;
        chk("t6.go",         game_over, GO_EXP);
        chk("t6.hold_state", cur_state, 4'h1);
        chk("t6.hold_grant", grant, 4'b0001);
        plot_done = 1'b1;
        cyc();
        plot_done = 1'b0;
        chk("t6.arb_state", cur_state, GO_EXP ? 4'hF : 4'hB);
        serve_slot(4'b0010, 2'd1, 4'h2, "t6.s2");
        cyc();
        chk("t6.idle_busy",  frame_busy, 0);
        chk("t6.idle_state", cur_state, GO_EXP ? 4'hF : 4'hB);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("t6.tick_bg",   bg_active, !GO_EXP);
        chk("t6.tick_busy", frame_busy, !GO_EXP);
        chk("t6.tick_ovr",  frame_overrun, 0);
        chk("t6.go_final",  game_over, GO_EXP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
